// File: rtl/rf_pkg.sv
// Shared register-file write-back types: widths, zero register, buffered result entry.
// Pure declarations, no latency; no flow control lives here.
// Backpressure: not applicable.
package rf_pkg;
    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back entries with full/empty/count status.
// Latency: an entry pushed at edge N is visible at the head after edge N; head is combinational.
// Backpressure: push is ignored while full, pop is ignored while empty.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/rf_wb_sched.sv
// Shares the GPR write port between the W stage (priority) and a long-latency unit; busy scoreboard.
// Latency: W-stage write 0 cycles; unit result accepted at edge N is written at edge N+1 earliest.
// Backpressure: lu_done_ready drops while the buffer is full; RF_WB_STARVE_GUARD_EN adds hold_req.
module rf_wb_sched
    import rf_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_a3,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              lu_issue,
    input  logic [REG_W-1:0]  lu_issue_a3,
    output logic              lu_issue_ready,
    input  logic              lu_done_valid,
    input  logic [REG_W-1:0]  lu_done_a3,
    input  logic [DATA_W-1:0] lu_done_wd,
    input  logic [DATA_W-1:0] lu_done_pc,
    output logic              lu_done_ready,
    input  logic [REG_W-1:0]  rd_a1,
    input  logic [REG_W-1:0]  rd_a2,
    output logic              stall,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] rf_pc
`ifdef RF_WB_STARVE_GUARD_EN
    ,
    output logic              hold_req
`endif
);
    logic [31:0]            busy;
    logic [31:0]            busy_nxt;
    wb_entry_t              head;
    wb_entry_t              push_entry;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   pipe_win;
    logic                   push;
    logic                   pop;
    logic                   issue_fire;
    logic                   unused_count;

    assign unused_count = ^count;

    assign pipe_win   = pipe_we & (pipe_a3 != REG_ZERO);
    assign pop        = ~reset & ~pipe_win & ~empty;
    assign push       = lu_done_valid & lu_done_ready & (lu_done_a3 != REG_ZERO);
    assign push_entry = '{a3: lu_done_a3, wd: lu_done_wd, pc: lu_done_pc};

    assign lu_done_ready  = ~full;
    assign lu_issue_ready = ~busy[lu_issue_a3];
    assign issue_fire     = lu_issue & lu_issue_ready & (lu_issue_a3 != REG_ZERO);
    assign stall          = busy[rd_a1] | busy[rd_a2];

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Outputs are gated during reset so the register file never sees a write while state is cleared.
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        rf_pc = '0;
        if (!reset) begin
            if (pipe_win) begin
                rf_we = 1'b1;
                rf_a3 = pipe_a3;
                rf_wd = pipe_wd;
                rf_pc = pipe_pc;
            end else if (!empty) begin
                rf_we = 1'b1;
                rf_a3 = head.a3;
                rf_wd = head.wd;
                rf_pc = head.pc;
            end
        end
    end

    // Set and clear never collide: issue to a busy register is refused.
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head.a3] = 1'b0;
        end
        if (issue_fire) begin
            busy_nxt[lu_issue_a3] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    logic          blocked;

    assign blocked  = pipe_win & ~empty & ~reset;
    // Pulses on the blocked cycle that brings the run length to the limit.
    assign hold_req = blocked & (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (hold_req || !blocked) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench for rf_wb_sched: expected register-file writes are queued by stimulus,
// a negedge monitor pops and compares every rf_we cycle; status outputs are checked directly.
module tb_rf_wb_sched;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              pipe_we;
    logic [REG_W-1:0]  pipe_a3;
    logic [DATA_W-1:0] pipe_wd;
    logic [DATA_W-1:0] pipe_pc;
    logic              lu_issue;
    logic [REG_W-1:0]  lu_issue_a3;
    logic              lu_issue_ready;
    logic              lu_done_valid;
    logic [REG_W-1:0]  lu_done_a3;
    logic [DATA_W-1:0] lu_done_wd;
    logic [DATA_W-1:0] lu_done_pc;
    logic              lu_done_ready;
    logic [REG_W-1:0]  rd_a1;
    logic [REG_W-1:0]  rd_a2;
    logic              stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_a3;
    logic [DATA_W-1:0] rf_wd;
    logic [DATA_W-1:0] rf_pc;
`ifdef RF_WB_STARVE_GUARD_EN
    logic              hold_req;
`endif

    int checks = 0;
    int errors = 0;
    wb_entry_t exp_q[$];

    always #5 clk = ~clk;

    rf_wb_sched dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_we        (pipe_we),
        .pipe_a3        (pipe_a3),
        .pipe_wd        (pipe_wd),
        .pipe_pc        (pipe_pc),
        .lu_issue       (lu_issue),
        .lu_issue_a3    (lu_issue_a3),
        .lu_issue_ready (lu_issue_ready),
        .lu_done_valid  (lu_done_valid),
        .lu_done_a3     (lu_done_a3),
        .lu_done_wd     (lu_done_wd),
        .lu_done_pc     (lu_done_pc),
        .lu_done_ready  (lu_done_ready),
        .rd_a1          (rd_a1),
        .rd_a2          (rd_a2),
        .stall          (stall),
        .rf_we          (rf_we),
        .rf_a3          (rf_a3),
        .rf_wd          (rf_wd),
        .rf_pc          (rf_pc)
`ifdef RF_WB_STARVE_GUARD_EN
        ,
        .hold_req       (hold_req)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        lu_issue = 0; lu_issue_a3 = 0;
        lu_done_valid = 0; lu_done_a3 = 0; lu_done_wd = 0; lu_done_pc = 0;
        rd_a1 = 0; rd_a2 = 0;
    endtask

    task automatic pipe_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        pipe_we = 1; pipe_a3 = a3; pipe_wd = wd; pipe_pc = pc;
        exp_q.push_back('{a3: a3, wd: wd, pc: pc});
    endtask

    // Caller queues the buffered entry separately, at the point it is due in write order.
    task automatic unit_done(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        lu_done_valid = 1; lu_done_a3 = a3; lu_done_wd = wd; lu_done_pc = pc;
    endtask

    task automatic expect_wr(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        exp_q.push_back('{a3: a3, wd: wd, pc: pc});
    endtask

    // Monitor: every register-file write must match the next queued expectation.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got a3=%0d wd=0x%08h pc=0x%08h, required no write",
                             rf_a3, rf_wd, rf_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (rf_a3 !== e.a3 || rf_wd !== e.wd || rf_pc !== e.pc) begin
                        errors++;
                        $display("FAIL wr_data: got a3=%0d wd=0x%08h pc=0x%08h, required a3=%0d wd=0x%08h pc=0x%08h",
                                 rf_a3, rf_wd, rf_pc, e.a3, e.wd, e.pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_done_rdy", lu_done_ready, 1);
        chk("rst_issue_rdy", lu_issue_ready, 1);
        chk("rst_stall", stall, 0);
        tick();

        // Stall release
        lu_issue = 1; lu_issue_a3 = 5;
        @(negedge clk); chk("iss5_rdy", lu_issue_ready, 1);
        tick();
        lu_issue = 0; rd_a1 = 5;
        @(negedge clk); chk("stall5_set", stall, 1); chk("iss5_blk", lu_issue_ready, 0);
        tick();
        unit_done(5, 32'h1234, 32'h100); expect_wr(5, 32'h1234, 32'h100);
        @(negedge clk); chk("done5_no_wr_yet", rf_we, 0); chk("stall5_hold", stall, 1);
        tick();
        lu_done_valid = 0;
        @(negedge clk); chk("wr5_we", rf_we, 1); chk("stall5_at_wr", stall, 1);
        tick();
        @(negedge clk); chk("stall5_clr", stall, 0);
        tick();
        idle();

        // W-stage priority with a full buffer
        lu_issue = 1; lu_issue_a3 = 8; tick();
        lu_issue_a3 = 9; tick();
        lu_issue = 0; rd_a1 = 8; rd_a2 = 9;
        pipe_wr(1, 32'hA1, 32'h200); unit_done(8, 32'h88, 32'h300);
        @(negedge clk); chk("pri_rdy0", lu_done_ready, 1);
        tick();
        pipe_wr(2, 32'hA2, 32'h204); unit_done(9, 32'h99, 32'h304);
        @(negedge clk); chk("pri_rdy1", lu_done_ready, 1);
        tick();
        lu_done_valid = 0; pipe_wr(3, 32'hA3, 32'h208);
        @(negedge clk); chk("pri_full", lu_done_ready, 0); chk("pri_stall", stall, 1);
        tick();
        pipe_wr(4, 32'hA4, 32'h20C);
        @(negedge clk); chk("pri_full2", lu_done_ready, 0);
        tick();
        pipe_we = 0; expect_wr(8, 32'h88, 32'h300);
        @(negedge clk); chk("drain1_a3", rf_a3, 8);
        tick();
        expect_wr(9, 32'h99, 32'h304);
        @(negedge clk); chk("drain2_rdy", lu_done_ready, 1); chk("drain2_a3", rf_a3, 9);
        tick();
        @(negedge clk); chk("drain_stall", stall, 0); chk("drain_idle", rf_we, 0);
        tick();
        idle();

        // Zero register
        lu_issue = 1; lu_issue_a3 = 0;
        @(negedge clk); chk("z_iss_rdy", lu_issue_ready, 1);
        tick();
        lu_issue = 0; unit_done(0, 32'hDEAD, 32'h400);
        @(negedge clk); chk("z_done_rdy", lu_done_ready, 1);
        tick();
        lu_done_valid = 0; pipe_we = 1; pipe_a3 = 0; pipe_wd = 32'hBEEF;
        @(negedge clk); chk("z_no_wr", rf_we, 0);
        tick();
        idle();

        // Write-after-write on the unit
        lu_issue = 1; lu_issue_a3 = 7;
        @(negedge clk); chk("waw_first", lu_issue_ready, 1);
        tick();
        @(negedge clk); chk("waw_second", lu_issue_ready, 0);
        tick();
        lu_issue = 0; unit_done(7, 32'h77, 32'h500); expect_wr(7, 32'h77, 32'h500);
        tick();
        lu_done_valid = 0;
        @(negedge clk); chk("waw_at_wr", lu_issue_ready, 0);
        tick();
        @(negedge clk); chk("waw_release", lu_issue_ready, 1);
        tick();
        idle();

        // Reset with full buffer and busy = 0x30
        lu_issue = 1; lu_issue_a3 = 4; tick();
        lu_issue_a3 = 5; tick();
        lu_issue = 0;
        pipe_wr(1, 32'hB1, 32'h600); unit_done(4, 32'h44, 32'h610); tick();
        pipe_wr(2, 32'hB2, 32'h604); unit_done(5, 32'h55, 32'h614); tick();
        idle(); rd_a1 = 4; rd_a2 = 5; reset = 1;
        @(negedge clk); chk("rstmid_full", lu_done_ready, 0); chk("rstmid_busy", stall, 1);
        tick();
        reset = 0;
        @(negedge clk); chk("rstmid_we", rf_we, 0); chk("rstmid_rdy", lu_done_ready, 1);
        chk("rstmid_stall", stall, 0);
        tick(); tick();
        idle();

`ifdef RF_WB_STARVE_GUARD_EN
        lu_issue = 1; lu_issue_a3 = 10; tick();
        lu_issue = 0;
        pipe_wr(1, 32'hC0, 32'h700); unit_done(10, 32'hAA, 32'h710);
        @(negedge clk); chk("sg_hold_c0", hold_req, 0);
        tick();
        lu_done_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            pipe_wr(2, 32'hC0 + k, 32'h700 + 4 * k);
            @(negedge clk); chk($sformatf("sg_hold_c%0d", k), hold_req, (k == 8) ? 1 : 0);
            tick();
        end
        pipe_we = 0; expect_wr(10, 32'hAA, 32'h710);
        @(negedge clk); chk("sg_wr_c9", rf_a3, 10); chk("sg_hold_c9", hold_req, 0);
        tick();
        idle();
`endif

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wr_missing: %0d expected writes never appeared, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
